// File: rtl/dac_share_arbiter.sv
// Round-robin sharing of the SPI DAC serializer between two sample sources.
// One-entry holds per channel, dacdav/davdac handshake, gap and timeout.
module dac_share_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GAP_CYCLES     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ch0_valid,
  input  logic [15:0] ch0_data,
  input  logic        ch1_valid,
  input  logic [15:0] ch1_data,
  input  logic        davdac,
  input  logic        err_clr,
  output logic        dacdav,
  output logic [15:0] dac_data,
  output logic        dac_sel,
  output logic        ch0_pending,
  output logic        ch1_pending,
  output logic        busy,
  output logic        timeout_err,
  output logic [7:0]  ch0_ovr_cnt,
  output logic [7:0]  ch1_ovr_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    GAP
  } state_t;

  localparam logic [15:0] TO_LAST =
    16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] GAP_LAST =
    8'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  state_t      state;
  logic [15:0] hold0;
  logic [15:0] hold1;
  logic        last_grant;
  logic        sync1;
  logic        sync2;
  logic        sync3;
  logic [15:0] tcnt;
  logic [7:0]  gcnt;
  logic        rise;
  logic        gnt0;
  logic        gnt1;
  logic        to_hit;

  assign busy = (state != IDLE);
  assign rise = sync2 & ~sync3;
  assign to_hit = (state == WAIT) && !rise &&
                  (tcnt == TO_LAST);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE) begin
      if (ch0_pending && (!ch1_pending || last_grant))
        gnt0 = 1'b1;
      else if (ch1_pending)
        gnt1 = 1'b1;
    end
  end

  // sync3 only serves edge detection on the synchronized level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= davdac;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold0       <= '0;
      ch0_pending <= 1'b0;
      ch0_ovr_cnt <= '0;
    end else if (ch0_valid) begin
      hold0       <= ch0_data;
      ch0_pending <= 1'b1;
      if (ch0_pending && !gnt0 &&
          ch0_ovr_cnt != 8'hff)
        ch0_ovr_cnt <= ch0_ovr_cnt + 8'd1;
    end else if (gnt0) begin
      ch0_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold1       <= '0;
      ch1_pending <= 1'b0;
      ch1_ovr_cnt <= '0;
    end else if (ch1_valid) begin
      hold1       <= ch1_data;
      ch1_pending <= 1'b1;
      if (ch1_pending && !gnt1 &&
          ch1_ovr_cnt != 8'hff)
        ch1_ovr_cnt <= ch1_ovr_cnt + 8'd1;
    end else if (gnt1) begin
      ch1_pending <= 1'b0;
    end
  end

  // set wins over clear so a coincident timeout is never lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      timeout_err <= 1'b0;
    else if (to_hit)
      timeout_err <= 1'b1;
    else if (err_clr)
      timeout_err <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dacdav     <= 1'b0;
      dac_data   <= '0;
      dac_sel    <= 1'b0;
      last_grant <= 1'b1;
      tcnt       <= '0;
      gcnt       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            dac_data   <= gnt0 ? hold0 : hold1;
            dac_sel    <= gnt1;
            last_grant <= gnt1;
            dacdav     <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          dacdav <= 1'b0;
          tcnt   <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          if (rise) begin
            gcnt  <= '0;
            state <= (GAP_CYCLES == 0) ? IDLE : GAP;
          end else if (tcnt == TO_LAST) begin
            state <= IDLE;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        GAP: begin
          if (gcnt == GAP_LAST)
            state <= IDLE;
          else
            gcnt <= gcnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_share_arbiter.sv
// Directed bench for dac_share_arbiter with TIMEOUT_CYCLES=16, GAP_CYCLES=2.
module tb_dac_share_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ch0_valid = 1'b0;
  logic [15:0] ch0_data = '0;
  logic        ch1_valid = 1'b0;
  logic [15:0] ch1_data = '0;
  logic        davdac = 1'b0;
  logic        err_clr = 1'b0;
  logic        dacdav;
  logic [15:0] dac_data;
  logic        dac_sel;
  logic        ch0_pending;
  logic        ch1_pending;
  logic        busy;
  logic        timeout_err;
  logic [7:0]  ch0_ovr_cnt;
  logic [7:0]  ch1_ovr_cnt;

  int total = 0;
  int bad = 0;

  dac_share_arbiter #(
    .TIMEOUT_CYCLES(16),
    .GAP_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ch0_valid(ch0_valid),
    .ch0_data(ch0_data),
    .ch1_valid(ch1_valid),
    .ch1_data(ch1_data),
    .davdac(davdac),
    .err_clr(err_clr),
    .dacdav(dacdav),
    .dac_data(dac_data),
    .dac_sel(dac_sel),
    .ch0_pending(ch0_pending),
    .ch1_pending(ch1_pending),
    .busy(busy),
    .timeout_err(timeout_err),
    .ch0_ovr_cnt(ch0_ovr_cnt),
    .ch1_ovr_cnt(ch1_ovr_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // completion during WAIT, then 2 gap cycles back to IDLE
  task automatic finish_txn();
    davdac = 1'b1;
    repeat (3) tick();
    davdac = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    logic seen;
    do_reset();

    chk("rst_dacdav", 32'(dacdav), 32'h0);
    chk("rst_data", 32'(dac_data), 32'h0);
    chk("rst_pend", 32'({ch0_pending, ch1_pending}), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(timeout_err), 32'h0);
    chk("rst_ovr", 32'({ch0_ovr_cnt, ch1_ovr_cnt}), 32'h0);

    // single sample
    ch0_valid = 1'b1;
    ch0_data  = 16'h1234;
    tick();
    ch0_valid = 1'b0;
    chk("single_pend", 32'(ch0_pending), 32'h1);
    chk("single_nodav", 32'(dacdav), 32'h0);
    tick();
    chk("single_dav", 32'(dacdav), 32'h1);
    chk("single_data", 32'(dac_data), 32'h1234);
    chk("single_sel", 32'(dac_sel), 32'h0);
    chk("single_pclr", 32'(ch0_pending), 32'h0);
    tick();
    chk("single_davlo", 32'(dacdav), 32'h0);
    chk("single_busy", 32'(busy), 32'h1);
    davdac = 1'b1;
    repeat (3) tick();
    davdac = 1'b0;
    tick();
    chk("single_gap", 32'(busy), 32'h1);
    tick();
    chk("single_idle", 32'(busy), 32'h0);
    chk("single_hold", 32'(dac_data), 32'h1234);

    // tie: ch0 first after reset, then ch1, then ch0
    do_reset();
    ch0_valid = 1'b1;
    ch0_data  = 16'h0AAA;
    ch1_valid = 1'b1;
    ch1_data  = 16'h0555;
    tick();
    ch0_valid = 1'b0;
    ch1_valid = 1'b0;
    tick();
    chk("tie1_sel", 32'(dac_sel), 32'h0);
    chk("tie1_data", 32'(dac_data), 32'h0AAA);
    chk("tie1_p1", 32'(ch1_pending), 32'h1);
    finish_txn();
    tick();
    chk("tie2_sel", 32'(dac_sel), 32'h1);
    chk("tie2_data", 32'(dac_data), 32'h0555);
    chk("tie2_dav", 32'(dacdav), 32'h1);
    tick();
    finish_txn();
    ch0_valid = 1'b1;
    ch1_valid = 1'b1;
    tick();
    ch0_valid = 1'b0;
    ch1_valid = 1'b0;
    tick();
    chk("tie3_sel", 32'(dac_sel), 32'h0);

    // overrun while ch0 blocks the DAC
    do_reset();
    ch0_valid = 1'b1;
    ch0_data  = 16'h00C0;
    tick();
    ch0_valid = 1'b0;
    tick();
    for (int i = 1; i <= 3; i++) begin
      ch1_valid = 1'b1;
      ch1_data  = 16'(i);
      tick();
    end
    ch1_valid = 1'b0;
    chk("ovr_cnt1", 32'(ch1_ovr_cnt), 32'h2);
    chk("ovr_cnt0", 32'(ch0_ovr_cnt), 32'h0);
    chk("ovr_pend", 32'(ch1_pending), 32'h1);
    finish_txn();
    tick();
    chk("ovr_sel", 32'(dac_sel), 32'h1);
    chk("ovr_data", 32'(dac_data), 32'h0003);
    tick();
    finish_txn();

    // write coinciding with grant
    ch0_valid = 1'b1;
    ch0_data  = 16'h1111;
    tick();
    ch0_data  = 16'h2222;
    tick();
    ch0_valid = 1'b0;
    chk("coin_data", 32'(dac_data), 32'h1111);
    chk("coin_pend", 32'(ch0_pending), 32'h1);
    chk("coin_ovr", 32'(ch0_ovr_cnt), 32'h0);
    tick();
    finish_txn();
    tick();
    chk("coin_next", 32'(dac_data), 32'h2222);
    tick();
    finish_txn();

    // timeout with davdac held low
    ch0_valid = 1'b1;
    ch0_data  = 16'h7777;
    tick();
    ch0_valid = 1'b0;
    tick();
    chk("to_issue", 32'(dacdav), 32'h1);
    repeat (16) tick();
    chk("to_early", 32'(timeout_err), 32'h0);
    chk("to_busy", 32'(busy), 32'h1);
    err_clr = 1'b1;
    tick();
    chk("to_set", 32'(timeout_err), 32'h1);
    chk("to_idle", 32'(busy), 32'h0);
    tick();
    err_clr = 1'b0;
    chk("to_clr", 32'(timeout_err), 32'h0);

    // saturation: 300 back-to-back ch1 writes
    for (int i = 0; i < 300; i++) begin
      ch1_valid = 1'b1;
      ch1_data  = 16'(i);
      tick();
    end
    ch1_valid = 1'b0;
    chk("sat_cnt", 32'(ch1_ovr_cnt), 32'hFF);
    chk("sat_err", 32'(timeout_err), 32'h1);

    // asynchronous reset during a transaction
    do_reset();
    ch0_valid = 1'b1;
    ch1_valid = 1'b1;
    ch0_data  = 16'hBEEF;
    tick();
    ch0_valid = 1'b0;
    ch1_valid = 1'b0;
    tick();
    chk("ar_dav", 32'(dacdav), 32'h1);
    tick();
    rst = 1'b1;
    #2;
    chk("ar_davlo", 32'(dacdav), 32'h0);
    chk("ar_busy", 32'(busy), 32'h0);
    chk("ar_pend", 32'(ch1_pending), 32'h0);
    chk("ar_data", 32'(dac_data), 32'h0);
    tick();
    rst = 1'b0;
    davdac = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (dacdav || busy) seen = 1'b1;
    end
    davdac = 1'b0;
    chk("ar_late", 32'(seen), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
